video_sync_h: RTL and testbench

- Horizontal timing generator for the Pentagon/ATM video path.
- Counts pixel-clock strobes across a 448-pixel line.
- Produces the horizontal blank, sync and pixel-window levels.
- Also produces the one-shot line strobes (hsync_start, line_start, hint_start) that drive the vertical sync stage directly downstream, and the scan logic.

---
 rtl/video_timing_pkg.sv | 34 +++
 rtl/video_sync_h_strobe.sv | 23 ++
 rtl/video_sync_h.sv | 88 ++++++++
 tb/tb_video_sync_h.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared horizontal timing constants for the Pentagon/ATM video path.
// The vertical stage reuses the position width and mode encoding from here.
package video_timing;

    localparam int POS_W = 9;
    typedef logic [POS_W-1:0] hpos_t;

    // Mode encoding used by mode_atm_n_pent and the latched mode.
    localparam logic MODE_PENT = 1'b1;
    localparam logic MODE_ATM  = 1'b0;

    localparam hpos_t HPERIOD       = 9'd448;
    localparam hpos_t HLAST         = HPERIOD - 9'd1;
    localparam hpos_t HBLNK_BEG     = 9'd0;
    localparam hpos_t HSYNC_BEG     = 9'd10;
    localparam hpos_t HSYNC_END     = 9'd43;
    localparam hpos_t HBLNK_END     = 9'd88;
    localparam hpos_t HINT_BEG      = 9'd2;
    localparam hpos_t HPIX_BEG_PENT = 9'd140;
    localparam hpos_t HPIX_END_PENT = 9'd396;
    localparam hpos_t HPIX_BEG_ATM  = 9'd108;
    localparam hpos_t HPIX_END_ATM  = 9'd428;

    // Event ordering the downstream vertical stage relies on.
    function automatic bit params_legal();
        return (HBLNK_BEG < HSYNC_BEG) && (HSYNC_BEG < HSYNC_END) &&
               (HSYNC_END < HBLNK_END) &&
               (HBLNK_END <= HPIX_BEG_PENT) && (HPIX_BEG_PENT < HPIX_END_PENT) &&
               (HPIX_END_PENT < HPERIOD) &&
               (HBLNK_END <= HPIX_BEG_ATM) && (HPIX_BEG_ATM < HPIX_END_ATM) &&
               (HPIX_END_ATM < HPERIOD);
    endfunction

endpackage

// File: rtl/video_sync_h_strobe.sv
// One-clk strobe registered on the cend edge where hcount equals AT.
module video_strobe_at
    import video_timing::*;
#(
    parameter hpos_t AT = 9'd0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  cend,
    input  hpos_t hcount,
    output logic  strobe
);

    // Re-evaluated every clk so the strobe never outlives one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe <= 1'b0;
        end else begin
            strobe <= cend && (hcount == AT);
        end
    end

endmodule

// File: rtl/video_sync_h.sv
// Horizontal timing generator: line counter, blank/sync/pixel-window levels
// and the one-shot line strobes feeding the vertical stage.
module video_sync_h
    import video_timing::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cend,
    input  logic              mode_atm_n_pent,
    output logic              hblank,
    output logic              hsync,
    output logic              hpix,
    output logic              hsync_start,
    output logic              line_start,
    output logic              hint_start,
    output logic [POS_W-1:0]  hcount
);

    logic  mode_latched;
    hpos_t hpix_beg;
    hpos_t hpix_end;

    assign hpix_beg = (mode_latched == MODE_PENT) ? HPIX_BEG_PENT : HPIX_BEG_ATM;
    assign hpix_end = (mode_latched == MODE_PENT) ? HPIX_END_PENT : HPIX_END_ATM;

    // Mode is only taken at the line wrap so a window is never cut short or doubled.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount       <= '0;
            hblank       <= 1'b0;
            hsync        <= 1'b0;
            hpix         <= 1'b0;
            mode_latched <= MODE_PENT;
        end else if (cend) begin
            if (hcount == HLAST) begin
                hcount       <= '0;
                mode_latched <= mode_atm_n_pent;
            end else begin
                hcount <= hcount + 9'd1;
            end

            if (hcount == HBLNK_BEG) begin
                hblank <= 1'b1;
            end else if (hcount == HBLNK_END) begin
                hblank <= 1'b0;
            end

            if (hcount == HSYNC_BEG) begin
                hsync <= 1'b1;
            end else if (hcount == HSYNC_END) begin
                hsync <= 1'b0;
            end

            if (hcount == hpix_beg) begin
                hpix <= 1'b1;
            end else if (hcount == hpix_end) begin
                hpix <= 1'b0;
            end
        end
    end

    video_strobe_at #(.AT(HSYNC_BEG)) u_hsync_start (
        .clk    (clk),
        .rst    (rst),
        .cend   (cend),
        .hcount (hcount),
        .strobe (hsync_start)
    );

    video_strobe_at #(.AT(HBLNK_END)) u_line_start (
        .clk    (clk),
        .rst    (rst),
        .cend   (cend),
        .hcount (hcount),
        .strobe (line_start)
    );

    video_strobe_at #(.AT(HINT_BEG)) u_hint_start (
        .clk    (clk),
        .rst    (rst),
        .cend   (cend),
        .hcount (hcount),
        .strobe (hint_start)
    );

    params_ok: assert property (@(posedge clk) params_legal());

endmodule

// File: tb/tb_video_sync_h.sv
// Directed bench for video_sync_h: table of per-cend checkpoints plus
// hand-written stall, reset and pulse-spacing sequences.
module tb_video_sync_h;

    logic       clk = 1'b0;
    logic       rst;
    logic       cend;
    logic       mode_atm_n_pent;
    logic       hblank, hsync, hpix;
    logic       hsync_start, line_start, hint_start;
    logic [8:0] hcount;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    video_sync_h dut (
        .clk             (clk),
        .rst             (rst),
        .cend            (cend),
        .mode_atm_n_pent (mode_atm_n_pent),
        .hblank          (hblank),
        .hsync           (hsync),
        .hpix            (hpix),
        .hsync_start     (hsync_start),
        .line_start      (line_start),
        .hint_start      (hint_start),
        .hcount          (hcount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic       mode_in;
        logic [8:0] hcount;
        logic       hblank;
        logic       hsync;
        logic       hpix;
        logic       hs;
        logic       ls;
        logic       hi;
    } vec_t;

    vec_t vecs[$];

    // Independent observers: pulse counts, widths, spacing and hpix duty.
    logic mon_en = 1'b0;
    int   clk_cnt = 0;
    int   hs_cnt = 0, ls_cnt = 0, hi_cnt = 0;
    int   ts_hs = 0, ts_ls = 0, ts_hi = 0;
    int   wide_cnt = 0, hpix_rise = 0, hpix_clks = 0;
    logic prev_hs = 1'b0, prev_ls = 1'b0, prev_hi = 1'b0, prev_hpix = 1'b0;

    always @(posedge clk) clk_cnt <= clk_cnt + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (hsync_start) begin hs_cnt <= hs_cnt + 1; ts_hs <= clk_cnt; end
            if (line_start)  begin ls_cnt <= ls_cnt + 1; ts_ls <= clk_cnt; end
            if (hint_start)  begin hi_cnt <= hi_cnt + 1; ts_hi <= clk_cnt; end
            if ((hsync_start && prev_hs) || (line_start && prev_ls) || (hint_start && prev_hi))
                wide_cnt <= wide_cnt + 1;
            if (hpix && !prev_hpix) hpix_rise <= hpix_rise + 1;
            if (hpix) hpix_clks <= hpix_clks + 1;
            prev_hs   <= hsync_start;
            prev_ls   <= line_start;
            prev_hi   <= hint_start;
            prev_hpix <= hpix;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cend %0d: got %0d, want %0d", name, n, act, exp);
        end
    endtask

    task automatic check_vec(input vec_t v);
        check_output("hcount",      32'(hcount),      32'(v.hcount));
        check_output("hblank",      32'(hblank),      32'(v.hblank));
        check_output("hsync",       32'(hsync),       32'(v.hsync));
        check_output("hpix",        32'(hpix),        32'(v.hpix));
        check_output("hsync_start", 32'(hsync_start), 32'(v.hs));
        check_output("line_start",  32'(line_start),  32'(v.ls));
        check_output("hint_start",  32'(hint_start),  32'(v.hi));
    endtask

    // One cend strobe; returns 1 time unit after the capturing edge.
    task automatic apply_stimulus();
        @(negedge clk);
        cend = 1'b1;
        @(posedge clk);
        #1;
        cend = 1'b0;
        n++;
    endtask

    task automatic run_to(input int target);
        while (n < target) begin
            apply_stimulus();
            if (n < target) repeat (3) @(posedge clk);
        end
    endtask

    // Next clk after a checkpoint: pulses gone, hcount unchanged.
    task automatic tail_check(input logic [8:0] exp_hcount);
        @(posedge clk);
        #1;
        check_output("pulse_clear_hs", 32'(hsync_start), 32'd0);
        check_output("pulse_clear_ls", 32'(line_start),  32'd0);
        check_output("pulse_clear_hi", 32'(hint_start),  32'd0);
        check_output("hold_hcount",    32'(hcount),      32'(exp_hcount));
        repeat (2) @(posedge clk);
    endtask

    task automatic expect_all_zero(input string tag);
        check_output({tag, "_hcount"}, 32'(hcount), 32'd0);
        check_output({tag, "_hblank"}, 32'(hblank), 32'd0);
        check_output({tag, "_hsync"},  32'(hsync),  32'd0);
        check_output({tag, "_hpix"},   32'(hpix),   32'd0);
        check_output({tag, "_hs"},     32'(hsync_start), 32'd0);
        check_output({tag, "_ls"},     32'(line_start),  32'd0);
        check_output({tag, "_hi"},     32'(hint_start),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cend %0d", n);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int line_mark;
        int pulse_snap;
        int exp_line;

        // n, mode_in, hcount, hblank, hsync, hpix, hs, ls, hi
        vecs.push_back(vec_t'{1,    1'b1, 9'd1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{2,    1'b1, 9'd2,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{3,    1'b1, 9'd3,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{10,   1'b1, 9'd10,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{11,   1'b1, 9'd11,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{43,   1'b1, 9'd43,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{44,   1'b1, 9'd44,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{88,   1'b1, 9'd88,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{89,   1'b1, 9'd89,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{140,  1'b1, 9'd140, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{141,  1'b1, 9'd141, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{396,  1'b1, 9'd396, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{397,  1'b1, 9'd397, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{447,  1'b1, 9'd447, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{448,  1'b1, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{449,  1'b1, 9'd1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{451,  1'b1, 9'd3,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{459,  1'b1, 9'd11,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{537,  1'b1, 9'd89,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{589,  1'b1, 9'd141, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{649,  1'b0, 9'd201, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{845,  1'b0, 9'd397, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{896,  1'b0, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{897,  1'b0, 9'd1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1004, 1'b0, 9'd108, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1005, 1'b0, 9'd109, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1324, 1'b0, 9'd428, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1325, 1'b0, 9'd429, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1344, 1'b0, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        rst = 1'b1;
        cend = 1'b0;
        mode_atm_n_pent = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        expect_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        n = 0;
        line_mark = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_to(vecs[i].n);
            check_vec(vecs[i]);
            mode_atm_n_pent = vecs[i].mode_in;
            if ((vecs[i].n % 448) == 0) begin
                exp_line = (vecs[i].n == 1344) ? 1280 : 1024;
                check_output("hpix_clks_per_line", 32'(hpix_clks - line_mark), 32'(exp_line));
                line_mark = hpix_clks;
            end
            tail_check(vecs[i].hcount);
        end

        check_output("hsync_start_count", 32'(hs_cnt), 32'd3);
        check_output("line_start_count",  32'(ls_cnt), 32'd3);
        check_output("hint_start_count",  32'(hi_cnt), 32'd3);
        check_output("hpix_rises",        32'(hpix_rise), 32'd3);
        check_output("wide_pulses",       32'(wide_cnt), 32'd0);
        check_output("hint_to_hsync_clks", 32'(ts_hs - ts_hi), 32'd32);
        check_output("hsync_to_line_clks", 32'(ts_ls - ts_hs), 32'd312);

        // cend held low for 100 clk at hcount 20.
        run_to(1364);
        check_output("stall_pre_hcount", 32'(hcount), 32'd20);
        check_output("stall_pre_hsync",  32'(hsync),  32'd1);
        pulse_snap = hs_cnt + ls_cnt + hi_cnt;
        repeat (100) @(posedge clk);
        #1;
        check_output("stall_hcount", 32'(hcount), 32'd20);
        check_output("stall_hsync",  32'(hsync),  32'd1);
        check_output("stall_pulses", 32'(hs_cnt + ls_cnt + hi_cnt), 32'(pulse_snap));
        run_to(1365);
        check_output("resume_hcount", 32'(hcount), 32'd21);
        check_output("resume_hsync",  32'(hsync),  32'd1);
        run_to(1388);
        check_output("resume_hsync_fall_hcount", 32'(hcount), 32'd44);
        check_output("resume_hsync_fall",        32'(hsync),  32'd0);

        // One-clk reset mid-line at hcount 300 (ATM window open).
        run_to(1644);
        check_output("prereset_hcount", 32'(hcount), 32'd300);
        check_output("prereset_hpix",   32'(hpix),   32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        expect_all_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        n = 0;

        run_to(1);
        check_output("rr_hblank", 32'(hblank), 32'd1);
        check_output("rr_hcount", 32'(hcount), 32'd1);
        run_to(3);
        check_output("rr_hint", 32'(hint_start), 32'd1);
        run_to(11);
        check_output("rr_hsync_start", 32'(hsync_start), 32'd1);
        check_output("rr_hsync",       32'(hsync),       32'd1);
        run_to(89);
        check_output("rr_line_start", 32'(line_start), 32'd1);
        check_output("rr_hblank_end", 32'(hblank),     32'd0);
        // Reset restores the Pentagon latch even though the input selects ATM.
        run_to(109);
        check_output("rr_pent_hpix_109", 32'(hpix), 32'd0);
        run_to(141);
        check_output("rr_pent_hpix_141", 32'(hpix), 32'd1);
        run_to(448);
        check_output("rr_wrap_hcount", 32'(hcount), 32'd0);
        run_to(557);
        check_output("rr_atm_hpix_109", 32'(hpix), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
